chain_core_sweep: RTL and testbench

//  Parametrised rope/chain segment core: owns NODES node positions (x,y) in registers and relaxes them

---
 rtl/chain_core_sweep_pkg.sv | 17 +
 rtl/chain_core_sweep_relax_unit.sv | 36 +++
 rtl/chain_core_sweep.sv | 166 ++++++++++++++++
 tb/tb_chain_core_sweep.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/chain_core_sweep_pkg.sv
// Shared types and helpers for the chain segment core.
// Build option CHAIN_CORE_DAMPING_EN is consumed by chain_core_sweep_relax_unit.
package chain_core_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int COORD_W = 32;

  function automatic int reset_x(int base, int idx, int spacing);
    return (base + idx) * spacing;
  endfunction

endpackage

// File: rtl/chain_core_sweep_relax_unit.sv
// One-axis constraint relaxation: new = (p + 2c + n) >>> 2.
// With CHAIN_CORE_DAMPING_EN the move toward target is scaled by 2^-DAMP_SHIFT.
module chain_core_sweep_relax_unit
  import chain_core_sweep_pkg::*;
#(
  parameter int W          = COORD_W,
  parameter int DAMP_SHIFT = 1
) (
  input  logic signed [W-1:0] p_i,
  input  logic signed [W-1:0] c_i,
  input  logic signed [W-1:0] n_i,
  output logic signed [W-1:0] new_o
);

`ifdef CHAIN_CORE_DAMPING_EN
  localparam bit DAMP_EN = 1'b1;
`else
  localparam bit DAMP_EN = 1'b0;
`endif
  localparam int SH = DAMP_EN ? DAMP_SHIFT : 0;

  logic signed [W+1:0] sum;
  logic signed [W-1:0] tgt;
  logic signed [W:0]   c_ext;
  logic signed [W:0]   diff;

  // W+2 bits hold p + 2c + n without overflow
  assign sum = $signed({{2{p_i[W-1]}}, p_i})
             + $signed({c_i[W-1], c_i, 1'b0})
             + $signed({{2{n_i[W-1]}}, n_i});
  assign tgt   = W'(sum >>> 2);
  assign c_ext = $signed({c_i[W-1], c_i});
  assign diff  = $signed({tgt[W-1], tgt}) - c_ext;
  assign new_o = W'(c_ext + (diff >>> SH));

endmodule

// File: rtl/chain_core_sweep.sv
// Rope segment core: Gauss-Seidel sweep over NODES nodes, PASSES passes per start.
// Damping selected at build time by CHAIN_CORE_DAMPING_EN.
module chain_core_sweep
  import chain_core_sweep_pkg::*;
#(
  parameter int NODES        = 5,
  parameter int W            = COORD_W,
  parameter int PASSES       = 2,
  parameter int NODE_BASE_ID = 0,
  parameter int SPACING      = 16,
  parameter int FIRST_CORE   = 0,
  parameter int DAMP_SHIFT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [W-1:0]       prev_core_last_x,
  input  logic [W-1:0]       prev_core_last_y,
  input  logic [W-1:0]       next_core_first_x,
  input  logic [W-1:0]       next_core_first_y,
  input  logic [W-1:0]       x_mouse,
  input  logic [W-1:0]       y_mouse,
  input  logic               is_last,
  output logic               busy,
  output logic               done,
  output logic [NODES*W-1:0] nodes_x,
  output logic [NODES*W-1:0] nodes_y
);

  localparam int IW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NODES - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  state_e state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [PW-1:0] pass_q;
  logic signed [W-1:0] x_q [NODES];
  logic signed [W-1:0] y_q [NODES];
  logic signed [W-1:0] prv_x_q, prv_y_q, nxt_x_q, nxt_y_q;
  logic signed [W-1:0] ms_x_q, ms_y_q;
  logic last_q;

  logic signed [W-1:0] px, cx, nx, py, cy, ny;
  logic signed [W-1:0] rx, ry, wx, wy;
  logic at_end;

  assign at_end = (idx_q == LAST_IDX) && (pass_q == LAST_PASS);

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SWEEP;
      ST_SWEEP: begin
        busy = 1'b1;
        if (at_end) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Neighbours read live registers, so earlier nodes of this pass are already updated
  always_comb begin
    px = prv_x_q;
    py = prv_y_q;
    nx = nxt_x_q;
    ny = nxt_y_q;
    cx = x_q[0];
    cy = y_q[0];
    for (int i = 0; i < NODES; i++) begin
      if (idx_q == IW'(i)) begin
        cx = x_q[i];
        cy = y_q[i];
        if (i > 0) begin
          px = x_q[(i > 0) ? i - 1 : 0];
          py = y_q[(i > 0) ? i - 1 : 0];
        end
        if (i < NODES - 1) begin
          nx = x_q[(i < NODES - 1) ? i + 1 : i];
          ny = y_q[(i < NODES - 1) ? i + 1 : i];
        end
      end
    end
  end

  chain_core_sweep_relax_unit #(
    .W(W), .DAMP_SHIFT(DAMP_SHIFT)
  ) u_relax_x (
    .p_i(px), .c_i(cx), .n_i(nx), .new_o(rx)
  );

  chain_core_sweep_relax_unit #(
    .W(W), .DAMP_SHIFT(DAMP_SHIFT)
  ) u_relax_y (
    .p_i(py), .c_i(cy), .n_i(ny), .new_o(ry)
  );

  // Mouse wins over the pin when a single-node core is both first and last
  always_comb begin
    wx = rx;
    wy = ry;
    if (idx_q == '0 && FIRST_CORE != 0) begin
      wx = cx;
      wy = cy;
    end
    if (idx_q == LAST_IDX && last_q) begin
      wx = ms_x_q;
      wy = ms_y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pass_q  <= '0;
      prv_x_q <= '0;
      prv_y_q <= '0;
      nxt_x_q <= '0;
      nxt_y_q <= '0;
      ms_x_q  <= '0;
      ms_y_q  <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < NODES; i++) begin
        x_q[i] <= W'(reset_x(NODE_BASE_ID, i, SPACING));
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        prv_x_q <= prev_core_last_x;
        prv_y_q <= prev_core_last_y;
        nxt_x_q <= next_core_first_x;
        nxt_y_q <= next_core_first_y;
        ms_x_q  <= x_mouse;
        ms_y_q  <= y_mouse;
        last_q  <= is_last;
        idx_q   <= '0;
        pass_q  <= '0;
      end
      if (state_q == ST_SWEEP) begin
        x_q[idx_q] <= wx;
        y_q[idx_q] <= wy;
        if (idx_q == LAST_IDX) begin
          idx_q  <= '0;
          pass_q <= pass_q + PW'(1);
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NODES; g++) begin : g_pack
    assign nodes_x[g*W +: W] = x_q[g];
    assign nodes_y[g*W +: W] = y_q[g];
  end

endmodule

// File: tb/tb_chain_core_sweep.sv
// Bench for chain_core_sweep: two configurations checked every cycle against a
// frame-level model, plus hand-computed literal expectations.
module tb_chain_core_sweep;

`ifdef CHAIN_CORE_DAMPING_EN
  localparam bit DAMP = 1'b1;
`else
  localparam bit DAMP = 1'b0;
`endif
  localparam int DS = 1;

  typedef logic signed [15:0] c_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, is_last;
  c_t pvx, pvy, nfx, nfy, mox, moy;
  logic busy_a, done_a, busy_b, done_b;
  logic [63:0] nx_a, ny_a;
  logic [47:0] nx_b, ny_b;

  chain_core_sweep #(
    .NODES(4), .W(16), .PASSES(1), .NODE_BASE_ID(0),
    .SPACING(16), .FIRST_CORE(1), .DAMP_SHIFT(DS)
  ) u_a (
    .clk(clk), .reset(reset), .start(start),
    .prev_core_last_x(pvx), .prev_core_last_y(pvy),
    .next_core_first_x(nfx), .next_core_first_y(nfy),
    .x_mouse(mox), .y_mouse(moy), .is_last(is_last),
    .busy(busy_a), .done(done_a), .nodes_x(nx_a), .nodes_y(ny_a)
  );

  chain_core_sweep #(
    .NODES(3), .W(16), .PASSES(2), .NODE_BASE_ID(2),
    .SPACING(16), .FIRST_CORE(0), .DAMP_SHIFT(DS)
  ) u_b (
    .clk(clk), .reset(reset), .start(start),
    .prev_core_last_x(pvx), .prev_core_last_y(pvy),
    .next_core_first_x(nfx), .next_core_first_y(nfy),
    .x_mouse(mox), .y_mouse(moy), .is_last(is_last),
    .busy(busy_b), .done(done_b), .nodes_x(nx_b), .nodes_y(ny_b)
  );

  int ncmp = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: per core, a phase (0 idle, 1 sweeping, 2 done) and a step count
  c_t mx [2][4];
  c_t my [2][4];
  c_t lp [2][2];
  c_t ln [2][2];
  c_t lm [2][2];
  bit ll [2];
  int mph [2];
  int ms [2];

  function automatic int nn(int k); return (k == 0) ? 4 : 3; endfunction
  function automatic int pp(int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int fc(int k); return (k == 0) ? 1 : 0; endfunction
  function automatic int bb(int k); return (k == 0) ? 0 : 2; endfunction

  function automatic c_t relax(c_t p, c_t c, c_t n);
    int t;
    t = (int'(p) + 2 * int'(c) + int'(n)) >>> 2;
    if (DAMP) t = int'(c) + ((t - int'(c)) >>> DS);
    return c_t'(t);
  endfunction

  task automatic step(int k);
    int j;
    c_t p, c, n, q;
    j = ms[k] % nn(k);
    for (int a = 0; a < 2; a++) begin
      c = (a == 0) ? mx[k][j] : my[k][j];
      if (j == 0) p = lp[k][a];
      else p = (a == 0) ? mx[k][j-1] : my[k][j-1];
      if (j == nn(k) - 1) n = ln[k][a];
      else n = (a == 0) ? mx[k][j+1] : my[k][j+1];
      q = relax(p, c, n);
      if (j == 0 && fc(k) == 1) q = c;
      if (j == nn(k) - 1 && ll[k]) q = lm[k][a];
      if (a == 0) mx[k][j] = q;
      else my[k][j] = q;
    end
    ms[k]++;
    if (ms[k] == nn(k) * pp(k)) mph[k] = 2;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        mph[k] = 0;
        ms[k]  = 0;
        for (int i = 0; i < nn(k); i++) begin
          mx[k][i] = c_t'((bb(k) + i) * 16);
          my[k][i] = '0;
        end
      end else if (mph[k] == 0) begin
        if (start) begin
          lp[k][0] = pvx; lp[k][1] = pvy;
          ln[k][0] = nfx; ln[k][1] = nfy;
          lm[k][0] = mox; lm[k][1] = moy;
          ll[k] = is_last;
          mph[k] = 1;
          ms[k] = 0;
        end
      end else if (mph[k] == 1) begin
        step(k);
      end else begin
        mph[k] = 0;
      end
    end
  end

  function automatic logic [63:0] pack(int k, bit ax);
    logic [63:0] v = '0;
    for (int i = 0; i < nn(k); i++)
      v[i*16 +: 16] = ax ? my[k][i] : mx[k][i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("A busy", 64'(busy_a), 64'(mph[0] != 0));
      check("A done", 64'(done_a), 64'(mph[0] == 2));
      check("A x", nx_a, pack(0, 1'b0));
      check("A y", ny_a, pack(0, 1'b1));
      check("B busy", 64'(busy_b), 64'(mph[1] != 0));
      check("B done", 64'(done_b), 64'(mph[1] == 2));
      check("B x", 64'(nx_b), pack(1, 1'b0));
      check("B y", 64'(ny_b), pack(1, 1'b1));
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic run(input int extra, input int rst_at, input bit mchg,
                     output int bca, output int bcb,
                     output int dat, output int dcnt);
    bca = 0; bcb = 0; dat = 0; dcnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (busy_a) bca++;
      if (busy_b) bcb++;
      if (done_a) begin dcnt++; dat = i; end
      start = (i == extra);
      reset = !(i == rst_at);
      if (mchg && i == 2) begin mox = 7; moy = 7; end
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  localparam logic [63:0] RST_XA = {16'd48, 16'd32, 16'd16, 16'd0};

  int bca, bcb, dat, dcnt;
  c_t y3;

  initial begin
    reset = 1'b0; start = 1'b0; is_last = 1'b0;
    pvx = 0; pvy = 0; nfx = 64; nfy = 0; mox = 0; moy = 0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset A x", nx_a, RST_XA);
    check("reset A y", ny_a, 64'd0);
    check("reset B x", 64'(nx_b), 64'({16'd64, 16'd48, 16'd32}));
    check("reset busy", 64'(busy_a), 64'd0);
    check("reset done", 64'(done_a), 64'd0);
    reset = 1'b1;

    run(0, 0, 1'b0, bca, bcb, dat, dcnt);
    check("eq busy cycles A", 64'(bca), 64'd5);
    check("eq done cycle A", 64'(dat), 64'd5);
    check("eq done count A", 64'(dcnt), 64'd1);
    check("eq busy cycles B", 64'(bcb), 64'd7);
    check("eq A x", nx_a, RST_XA);
    check("eq A y", ny_a, 64'd0);
    check("eq B x", 64'(nx_b), DAMP ? 64'({16'd59, 16'd46, 16'd28})
                                    : 64'({16'd56, 16'd44, 16'd25}));

    do_reset();
    nfy = 64;
    run(0, 0, 1'b0, bca, bcb, dat, dcnt);
    y3 = DAMP ? c_t'(8) : c_t'(16);
    check("pull A y", ny_a, {y3, 48'd0});
    check("pull A x", nx_a, RST_XA);

    do_reset();
    nfy = -64;
    run(0, 0, 1'b0, bca, bcb, dat, dcnt);
    y3 = DAMP ? c_t'(-8) : c_t'(-16);
    check("neg A y3", {48'd0, ny_a[63:48]}, {48'd0, y3});

    do_reset();
    nfy = 0; is_last = 1'b1; mox = 100; moy = 200;
    run(0, 0, 1'b1, bca, bcb, dat, dcnt);
    check("mouse A x3", 64'(nx_a[63:48]), 64'd100);
    check("mouse A y3", 64'(ny_a[63:48]), 64'd200);
    check("mouse A y2", 64'(ny_a[47:32]), 64'd0);
    check("mouse A x2", 64'(nx_a[47:32]), 64'd32);
    is_last = 1'b0; mox = 0; moy = 0;

    do_reset();
    run(2, 0, 1'b0, bca, bcb, dat, dcnt);
    check("ignore busy cycles", 64'(bca), 64'd5);
    check("ignore done count", 64'(dcnt), 64'd1);

    nfy = 64;
    run(0, 2, 1'b0, bca, bcb, dat, dcnt);
    check("abort done count", 64'(dcnt), 64'd0);
    check("abort A x", nx_a, RST_XA);
    check("abort A y", ny_a, 64'd0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
